soc_system_ocram_arb: RTL and testbench

Parametrised on-chip RAM with two Avalon-MM slave ports (s0, s1) sharing one single-port memory array through a round-robin arbiter. Supports pipelined reads with readdatavalid, configurable read latency, byte-enabled writes and an optional hardware clear-on-reset sequence. Successor to the 64-bit single-port OCRAM; sits on the HPS/fabric interconnect as a shared scratchpad between two masters.

---
 rtl/soc_system_ocram_arb.sv | 165 ++++++++++++++++
 tb/tb_soc_system_ocram_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_ocram_arb.sv
// soc_system_ocram_arb: dual-port Avalon-MM scratchpad over one
// single-port RAM, round-robin arbitrated, optional clear after reset.
module soc_system_ocram_arb #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    freeze,
    input  logic [ADDR_WIDTH-1:0]   s0_address,
    input  logic [DATA_WIDTH/8-1:0] s0_byteenable,
    input  logic                    s0_chipselect,
    input  logic                    s0_read,
    input  logic                    s0_write,
    input  logic [DATA_WIDTH-1:0]   s0_writedata,
    output logic                    s0_waitrequest,
    output logic [DATA_WIDTH-1:0]   s0_readdata,
    output logic                    s0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic                    s1_waitrequest,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    init_done
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit LAT2  = (READ_LATENCY == 2);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  prio;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] q2;
    logic                  v1, p1, v2, p2;
    logic                  last_v, last_p;
    logic [DATA_WIDTH-1:0] last_d;

    logic                  req0, req1, run_ok;
    logic                  gnt0, gnt1;
    logic                  wr_en, rd_en, init_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [BE_W-1:0]       acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata;

    assign req0   = s0_chipselect & (s0_read | s0_write);
    assign req1   = s1_chipselect & (s1_read | s1_write);
    assign run_ok = reset_n & clken & ~freeze & (state == RUN);

    // priority port wins only under contention
    assign gnt0 = run_ok & req0 & (~req1 | ~prio);
    assign gnt1 = run_ok & req1 & (~req0 | prio);

    assign s0_waitrequest = ~gnt0;
    assign s1_waitrequest = ~gnt1;

    assign wr_en   = (gnt0 & s0_write) | (gnt1 & s1_write);
    assign rd_en   = (gnt0 & s0_read & ~s0_write)
                   | (gnt1 & s1_read & ~s1_write);
    assign init_we = reset_n & clken & (state == INIT);

    assign last_v = LAT2 ? v2 : v1;
    assign last_p = LAT2 ? p2 : p1;
    assign last_d = LAT2 ? q2 : ram_q;

    // route the granted port onto the single RAM port
    always_comb begin
        acc_addr  = s0_address;
        acc_be    = s0_byteenable;
        acc_wdata = s0_writedata;
        if (gnt1) begin
            acc_addr  = s1_address;
            acc_be    = s1_byteenable;
            acc_wdata = s1_writedata;
        end
    end

    // single-port array: clear sweep, byte-lane writes, sync read
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (acc_be[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[acc_addr];
        end
    end

    // INIT/RUN sequencing and round-robin priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            init_cnt  <= '0;
            init_done <= 1'b0;
            prio      <= 1'b0;
        end else if (clken) begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                    if (run_ok & req0 & req1) begin
                        prio <= ~prio;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // tagged read pipeline steering data back to the requesting port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1               <= 1'b0;
            p1               <= 1'b0;
            v2               <= 1'b0;
            p2               <= 1'b0;
            q2               <= '0;
            s0_readdata      <= '0;
            s1_readdata      <= '0;
            s0_readdatavalid <= 1'b0;
            s1_readdatavalid <= 1'b0;
        end else if (clken) begin
            v1               <= rd_en;
            p1               <= gnt1;
            v2               <= v1;
            p2               <= p1;
            q2               <= ram_q;
            s0_readdatavalid <= last_v & ~last_p;
            s1_readdatavalid <= last_v & last_p;
            if (last_v & ~last_p) begin
                s0_readdata <= last_d;
            end
            if (last_v & last_p) begin
                s1_readdata <= last_d;
            end
        end
    end

endmodule

// File: tb/tb_soc_system_ocram_arb.sv
// tb_soc_system_ocram_arb: two DUTs (read latency 1 and 2) on shared
// stimulus, checked against a transaction-level memory/arbiter model.
module tb_soc_system_ocram_arb;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clken = 1'b1;
    logic          freeze = 1'b0;
    logic [AW-1:0] s0_address, s1_address;
    logic [BW-1:0] s0_byteenable, s1_byteenable;
    logic          s0_chipselect, s1_chipselect;
    logic          s0_read, s1_read, s0_write, s1_write;
    logic [DW-1:0] s0_writedata, s1_writedata;

    logic          wq0 [2];
    logic          wq1 [2];
    logic          rv0 [2];
    logic          rv1 [2];
    logic          idn [2];
    logic [DW-1:0] rd0 [2];
    logic [DW-1:0] rd1 [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        soc_system_ocram_arb #(
            .DATA_WIDTH    (DW),
            .ADDR_WIDTH    (AW),
            .READ_LATENCY  (g + 1),
            .CLEAR_ON_RESET(1)
        ) dut (
            .clk              (clk),
            .reset_n          (reset_n),
            .clken            (clken),
            .freeze           (freeze),
            .s0_address       (s0_address),
            .s0_byteenable    (s0_byteenable),
            .s0_chipselect    (s0_chipselect),
            .s0_read          (s0_read),
            .s0_write         (s0_write),
            .s0_writedata     (s0_writedata),
            .s0_waitrequest   (wq0[g]),
            .s0_readdata      (rd0[g]),
            .s0_readdatavalid (rv0[g]),
            .s1_address       (s1_address),
            .s1_byteenable    (s1_byteenable),
            .s1_chipselect    (s1_chipselect),
            .s1_read          (s1_read),
            .s1_write         (s1_write),
            .s1_writedata     (s1_writedata),
            .s1_waitrequest   (wq1[g]),
            .s1_readdata      (rd1[g]),
            .s1_readdatavalid (rv1[g]),
            .init_done        (idn[g])
        );
    end

    typedef struct {
        bit            p;
        logic [DW-1:0] d;
        int            ge;
    } rd_t;

    logic [DW-1:0] mem_m [DEPTH];
    rd_t           pend [$];
    bit            prio_m;
    int            init_left;
    int            ecnt = 0;
    bit            exp_rv [2][2];
    logic [DW-1:0] exp_rd [2][2];
    bit            r0, r1, g0, g1;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic check(string tag, int d, logic [DW-1:0] o,
                         logic [DW-1:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s lat%0d obs=%h exp=%h", tag, d + 1, o, e);
    endtask

    task automatic model_reset();
        pend.delete();
        prio_m    = 1'b0;
        init_left = DEPTH;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                exp_rv[d][p] = 1'b0;
                exp_rd[d][p] = '0;
            end
        end
    endtask

    task automatic access(bit p, bit wr, logic [AW-1:0] a,
                          logic [BW-1:0] be, logic [DW-1:0] wd);
        rd_t e;
        if (wr) begin
            for (int i = 0; i < BW; i++) begin
                if (be[i]) mem_m[a][8*i +: 8] = wd[8*i +: 8];
            end
        end else begin
            e.p  = p;
            e.d  = mem_m[a];
            e.ge = ecnt;
            pend.push_back(e);
        end
    endtask

    task automatic drive(int p, bit cs, bit rd, bit wr, logic [AW-1:0] a,
                         logic [BW-1:0] be, logic [DW-1:0] wd);
        if (p == 0) begin
            s0_chipselect = cs;  s0_read = rd;  s0_write = wr;
            s0_address = a;  s0_byteenable = be;  s0_writedata = wd;
        end else begin
            s1_chipselect = cs;  s1_read = rd;  s1_write = wr;
            s1_address = a;  s1_byteenable = be;  s1_writedata = wd;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_drive();
        clken  = ($urandom_range(0, 9) != 0);
        freeze = ($urandom_range(0, 7) == 0);
        for (int p = 0; p < 2; p++) begin
            drive(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
                  BW'($urandom), {$urandom, $urandom});
        end
    endtask

    // one clock: check outputs at negedge, advance model at posedge
    task automatic cycle();
        bit run;
        @(negedge clk);
        r0  = s0_chipselect && (s0_read || s0_write);
        r1  = s1_chipselect && (s1_read || s1_write);
        run = reset_n && clken && !freeze && (init_left == 0);
        g0  = run && r0 && (!r1 || !prio_m);
        g1  = run && r1 && (!r0 || prio_m);
        for (int d = 0; d < 2; d++) begin
            check("wait0", d, DW'(wq0[d]), DW'(!g0));
            check("wait1", d, DW'(wq1[d]), DW'(!g1));
            check("rdv0", d, DW'(rv0[d]), DW'(exp_rv[d][0]));
            check("rdv1", d, DW'(rv1[d]), DW'(exp_rv[d][1]));
            check("rdata0", d, rd0[d], exp_rd[d][0]);
            check("rdata1", d, rd1[d], exp_rd[d][1]);
            check("initdone", d, DW'(idn[d]), DW'(init_left == 0));
        end
        @(posedge clk);
        if (reset_n && clken) begin
            ecnt++;
            if (init_left > 0) begin
                init_left--;
                if (init_left == 0) begin
                    foreach (mem_m[i]) mem_m[i] = '0;
                end
            end else if (run && r0 && r1) begin
                prio_m = !prio_m;
            end
            if (g0) access(1'b0, s0_write, s0_address, s0_byteenable,
                           s0_writedata);
            if (g1) access(1'b1, s1_write, s1_address, s1_byteenable,
                           s1_writedata);
            for (int d = 0; d < 2; d++) begin
                exp_rv[d][0] = 1'b0;
                exp_rv[d][1] = 1'b0;
                foreach (pend[i]) begin
                    if (pend[i].ge + d + 1 == ecnt) begin
                        exp_rv[d][pend[i].p] = 1'b1;
                        exp_rd[d][pend[i].p] = pend[i].d;
                    end
                end
            end
            while (pend.size() > 0 && pend[0].ge + 2 <= ecnt) begin
                void'(pend.pop_front());
            end
        end
        #1;
    endtask

    initial begin
        model_reset();
        idle();
        repeat (3) cycle();
        reset_n = 1'b1;

        // clear sweep with a 3-cycle clken pause
        repeat (5) cycle();
        clken = 1'b0;
        repeat (3) cycle();
        clken = 1'b1;
        repeat (12) cycle();
        for (int d = 0; d < 2; d++) check("init_end", d, DW'(idn[d]), 64'd1);

        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 1'b1, 1'b1, 1'b0, AW'(a), '0, '0);
            cycle();
        end
        idle();
        repeat (3) cycle();

        // byte-lane merge
        drive(0, 1'b1, 1'b0, 1'b1, 4'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        drive(0, 1'b1, 1'b0, 1'b1, 4'd5, 8'h0F, 64'h1122_3344_5566_7788);
        cycle();
        drive(0, 1'b1, 1'b1, 1'b0, 4'd5, '0, '0);
        cycle();
        idle();
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            check("be_merge", d, rd0[d], 64'hFFFF_FFFF_5566_7788);
        end

        // contention every cycle
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, AW'(i), '0, '0);
            drive(1, 1'b1, 1'b1, 1'b0, AW'(i + 8), '0, '0);
            cycle();
        end
        idle();
        repeat (3) cycle();

        // freeze after an s1 read grant
        drive(1, 1'b1, 1'b1, 1'b0, 4'd5, '0, '0);
        cycle();
        idle();
        freeze = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 4'd3, '0, '0);
        repeat (3) cycle();
        freeze = 1'b0;
        cycle();
        idle();
        repeat (3) cycle();

        // clken stall mid-read
        drive(0, 1'b1, 1'b1, 1'b0, 4'd5, '0, '0);
        cycle();
        idle();
        clken = 1'b0;
        repeat (3) cycle();
        clken = 1'b1;
        repeat (4) cycle();

        repeat (600) begin
            rand_drive();
            cycle();
        end
        idle();
        clken  = 1'b1;
        freeze = 1'b0;
        repeat (3) cycle();

        // reset with reads in flight
        drive(0, 1'b1, 1'b1, 1'b0, 4'd1, '0, '0);
        drive(1, 1'b1, 1'b1, 1'b0, 4'd2, '0, '0);
        cycle();
        cycle();
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("rst_wait0", d, DW'(wq0[d]), 64'd1);
            check("rst_wait1", d, DW'(wq1[d]), 64'd1);
            check("rst_rdv0", d, DW'(rv0[d]), 64'd0);
            check("rst_rdv1", d, DW'(rv1[d]), 64'd0);
        end
        idle();
        repeat (3) cycle();
        reset_n = 1'b1;
        repeat (DEPTH) cycle();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 1'b1, 1'b1, 1'b0, AW'(a), '0, '0);
            cycle();
        end
        idle();
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
